// File: rtl/stream_mux_arb_if.sv
// Handshake bundle for stream_mux_arb: N valid/ready producer lanes and one registered consumer lane.
// "slave" is the mux side; "master" is the producer/consumer environment side.
interface stream_mux_arb_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/stream_mux_arb.sv
// N-channel stream mux with an internal arbiter and a one-slot registered output.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise lowest index wins.
module stream_mux_arb #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic            clk,
    input  logic            reset,
    stream_mux_arb_if.slave bus
);
    localparam int SELW = $clog2(N);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t              r_state;
    logic [WIDTH-1:0]   r_data_p1;
    logic [SELW-1:0]    r_sel_p1;

    logic               w_take;
    logic               w_any;
    logic               w_accept;
    logic [SELW-1:0]    w_grant;
    logic [SELW-1:0]    w_idx;
    logic [N-1:0]       w_ready;
    logic [WIDTH-1:0]   w_data;

    assign w_take   = (r_state == EMPTY) || bus.out_ready;
    assign w_any    = |bus.in_valid;
    assign w_accept = w_take && w_any && !reset;

`ifdef STREAM_MUX_RR_EN
    logic [SELW-1:0]    r_ptr;
    logic               w_found;

    // Scan starts one past the last winner so every requester is reached within N accepts.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_idx = SELW'((int'(r_ptr) + k) % N);
            if (!w_found && bus.in_valid[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = SELW'(k);
            if (bus.in_valid[w_idx]) begin
                w_grant = w_idx;
            end
        end
    end
`endif

    assign w_data = bus.in_data[int'(w_grant)*WIDTH +: WIDTH];

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    // Output slot: drains and refills on the same edge when both sides are ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= EMPTY;
            r_data_p1 <= '0;
            r_sel_p1  <= '0;
`ifdef STREAM_MUX_RR_EN
            r_ptr     <= SELW'(N - 1);
`endif
        end else if (w_take) begin
            if (w_any) begin
                r_state   <= FULL;
                r_data_p1 <= w_data;
                r_sel_p1  <= w_grant;
`ifdef STREAM_MUX_RR_EN
                r_ptr     <= w_grant;
`endif
            end else begin
                r_state   <= EMPTY;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_data_p1;
    assign bus.out_sel   = r_sel_p1;
    assign bus.out_valid = (r_state == FULL);
endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb; expectations follow whichever arbitration build is compiled.
module tb_stream_mux_arb;
    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stream_mux_arb_if #(.WIDTH(WIDTH), .N(N)) bus();

    stream_mux_arb #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic set_ch(input int ch, input logic [7:0] d);
        bus.in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.out_data); end
        checks++; if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", bus.out_sel); end
        for (int i = 0; i < N; i++) set_ch(i, 8'(8'h10 + i));
        bus.in_valid = 4'hF;
        #1;
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
        reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b want 0001", bus.in_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL first_sel: got %0d want 0", bus.out_sel); end
        checks++; if (bus.out_data !== 8'h10) begin errors++; $display("FAIL first_data: got %h want 10", bus.out_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        set_ch(0, 8'h5A);
        bus.in_valid = 4'b0001;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin errors++; $display("FAIL mid_load: got v=%b d=%h want v=1 d=5a", bus.out_valid, bus.out_data); end
        bus.in_valid = '0;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h want 00", bus.out_data); end
        checks++; if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL mid_reset_sel: got %0d want 0", bus.out_sel); end
        for (int i = 0; i < N; i++) set_ch(i, 8'(8'h10 + i));
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_in_ready: got %b want 0000", bus.in_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", bus.in_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.out_sel !== 2'd0 || bus.out_data !== 8'h10) begin errors++; $display("FAIL mid_first_word: got sel=%0d d=%h want sel=0 d=10", bus.out_sel, bus.out_data); end
    endtask

    task automatic test_sweep();
        int exp;
        do_reset();
        for (int i = 0; i < N; i++) set_ch(i, 8'(8'h10 + i));
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
`ifdef STREAM_MUX_RR_EN
            exp = c % 4;
`else
            exp = 0;
`endif
            @(negedge clk);
            checks++; if (bus.in_ready !== 4'(1 << exp)) begin errors++; $display("FAIL sweep_in_ready[%0d]: got %b want %b", c, bus.in_ready, 4'(1 << exp)); end
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(exp) || bus.out_data !== 8'(8'h10 + exp))
                begin errors++; $display("FAIL sweep_out[%0d]: got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h", c, bus.out_valid, bus.out_sel, bus.out_data, exp, 8'(8'h10 + exp)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b1;
        set_ch(2, 8'hC3);
        bus.in_valid = 4'b0100;
        @(posedge clk);
        #1;
        checks++; if (bus.out_sel !== 2'd2 || bus.out_data !== 8'hC3) begin errors++; $display("FAIL bp_load: got sel=%0d d=%h want sel=2 d=c3", bus.out_sel, bus.out_data); end
        set_ch(0, 8'h77);
        bus.in_valid  = 4'b0001;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, bus.in_ready); end
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 8'hC3)
                begin errors++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d d=%h want v=1 sel=2 d=c3", c, bus.out_valid, bus.out_sel, bus.out_data); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b want 0001", bus.in_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 8'h77)
            begin errors++; $display("FAIL bp_no_bubble: got v=%b sel=%0d d=%h want v=1 sel=0 d=77", bus.out_valid, bus.out_sel, bus.out_data); end
    endtask

    task automatic test_single();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            set_ch(2, 8'(8'h20 + c));
            @(negedge clk);
            checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready[%0d]: got %b want 0100", c, bus.in_ready); end
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 8'(8'h20 + c))
                begin errors++; $display("FAIL single_out[%0d]: got v=%b sel=%0d d=%h want v=1 sel=2 d=%h", c, bus.out_valid, bus.out_sel, bus.out_data, 8'(8'h20 + c)); end
        end
        bus.in_valid = '0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready: got %b want 0000", bus.in_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got v=%b want 0", bus.out_valid); end
        checks++; if (bus.out_sel !== 2'd2 || bus.out_data !== 8'h22) begin errors++; $display("FAIL single_hold: got sel=%0d d=%h want sel=2 d=22", bus.out_sel, bus.out_data); end
    endtask

    task automatic test_priority();
        int exp;
        do_reset();
        set_ch(1, 8'h31);
        set_ch(3, 8'h33);
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1010;
        for (int c = 0; c < 4; c++) begin
`ifdef STREAM_MUX_RR_EN
            exp = (c % 2 == 0) ? 1 : 3;
`else
            exp = 1;
`endif
            @(negedge clk);
            checks++; if (bus.in_ready !== 4'(1 << exp)) begin errors++; $display("FAIL prio_ready[%0d]: got %b want %b", c, bus.in_ready, 4'(1 << exp)); end
            @(posedge clk);
            #1;
            checks++; if (bus.out_sel !== 2'(exp) || bus.out_data !== 8'(8'h30 + exp))
                begin errors++; $display("FAIL prio_out[%0d]: got sel=%0d d=%h want sel=%0d d=%h", c, bus.out_sel, bus.out_data, exp, 8'(8'h30 + exp)); end
        end
        bus.in_valid = 4'b1000;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b1000) begin errors++; $display("FAIL prio_ch3_ready: got %b want 1000", bus.in_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.out_sel !== 2'd3 || bus.out_data !== 8'h33) begin errors++; $display("FAIL prio_ch3_out: got sel=%0d d=%h want sel=3 d=33", bus.out_sel, bus.out_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_sweep();
        test_backpressure();
        test_single();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and a registered output stage. It generalises the 2:1 single-bit select mux: the select is generated internally by an arbiter rather than driven externally, and one-slot buffering decouples upstream from downstream. It sits between several producers and one shared consumer, such as a shared bus or a serial transmitter.

## Interface
- `WIDTH`, 8: data bits per channel; must be ≥1.
- `N`, 4: number of input channels; must be ≥2.
- `SELW`, `$clog2(N)`: width of the channel index. Derived; not overridden.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `in_data` input, N*WIDTH bits: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid` input, N bits: bit i means channel i is offering data.
- `in_ready` output, N bits: bit i means channel i's data is taken this cycle. Combinational.
- `out_data` output, WIDTH bits: registered selected data.
- `out_sel` output, SELW bits: registered index of the channel that supplied `out_data`.
- `out_valid` output, 1 bit: registered; the output slot is full.
- `out_ready` input, 1 bit: the consumer accepts the output this cycle.

## Operation
**Slot state** (`out_valid` is the state bit):
- EMPTY: `out_valid`=0.
- FULL: `out_valid`=1.

**Rules:**
- `take = !out_valid || out_ready`. The slot can load this cycle.
- `grant`: combinational index chosen by the arbiter among the set bits of `in_valid`. `any = |in_valid`.
- `in_ready[i] = take && any && (i == grant)`. At most one bit is set. All bits are 0 when `take`=0.
- Accept (`take && any`):
  - next `out_data = in_data[grant]`
  - next `out_sel = grant`
  - next `out_valid = 1`
  - `ptr <= grant`
- `take && !any`: next `out_valid = 0`. `out_data` and `out_sel` hold their last values.
- FULL with `out_ready`=0: all output registers hold.

**Simultaneous events:**
- If `out_ready`=1 and accept happen in the same cycle, the slot drains and refills together. Throughput is 1 word per cycle.

**Round-robin arbitration** (when `STREAM_MUX_RR_EN` is defined):
- Scan order is `ptr+1, ptr+2, …`, wrapping modulo N.
- The first channel in scan order with `in_valid` set wins.
- `ptr` is a SELW-bit register. It changes only on accept.

**Upstream obligation:** `in_data[i]` and `in_valid[i]` stay stable until `in_ready[i]` is asserted. The block does not check this.

## Timing
- **Reset values** (asynchronous, immediate):
  - `out_valid`=0
  - `out_data`=0
  - `out_sel`=0
  - `ptr`=N-1, so channel 0 has first priority after reset.
  - `in_ready`=0 while `reset` is high.
- **Latency:** the word accepted at edge k appears on `out_data` with `out_valid`=1 after edge k. That is 1 cycle.
- **Combinational paths:** `in_ready` depends on `in_valid`, `out_valid`, `out_ready` and `ptr`. No path runs from `in_*` to `out_*` without a register.
- **Stability:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_sel` are stable.
- **Reset mid-operation:** any word in the slot is discarded. No `in_ready` pulse occurs during reset. Arbitration restarts at channel 0.
- **Wrap-around:** with `ptr`=N-1, the scan starts at channel 0.

## Configuration
- `STREAM_MUX_RR_EN` defined: round-robin arbitration as described above. Starvation-free: any requester is served within N accepts.
- Not defined: fixed priority. The lowest-index valid channel wins and `ptr` is not implemented. Higher channels can starve.
- All other behaviour is identical in both builds.

## Test plan
- **Reset mid-transfer:** assert `reset` while `out_valid`=1 and `out_data`=8'h5A. Outputs go to `out_valid`=0, `out_data`=0, `out_sel`=0 before the next edge. After release, first grant goes to channel 0 when all channels are valid.
- **Round-robin sweep** (RR build, N=4): hold `in_valid`=4'b1111 and `out_ready`=1, with data 8'h10+i. `out_sel` runs 0,1,2,3,0 on consecutive cycles; `out_data` runs 10,11,12,13,10; one `in_ready` bit per cycle.
- **Backpressure:** set `out_ready`=0 for 3 cycles while FULL with `out_sel`=2 and `out_data`=8'hC3. Outputs hold and `in_ready`=0. On `out_ready`=1, the next word loads on the same edge, giving no bubble.
- **Single channel:** only `in_valid[2]`=1, `out_ready`=1. `in_ready[2]`=1 every cycle and one word per cycle with `out_sel`=2. When `in_valid` drops, `out_valid` drops one cycle later.
- **Fixed-priority build:** `in_valid`=4'b1010 held, `out_ready`=1. `out_sel`=1 every cycle and channel 3 never gets `in_ready`. Once `in_valid[1]`=0, channel 3 is served the next cycle.
